// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment display path.
// Segment codes are active-low, bit order {dp,g,f,e,d,c,b,a}; dp is always off.
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] hex2seg(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/seg_hex_disp_if.sv
// seg_hex_disp_if: value/strobe/blank inputs and scanned segment/digit outputs.
// Handshake: din_vld is a one-cycle strobe with no ready; din is captured on
// every rising clk edge where din_vld=1, the last strobe before a frame
// boundary wins. seg/sel are registered, active-low.
interface seg_hex_disp_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] din;
  logic                din_vld;
  logic                blank;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   sel;

  modport master (output din, output din_vld, output blank, input seg, input sel);
  modport slave  (input din, input din_vld, input blank, output seg, output sel);
endinterface

// File: rtl/seg_hex_dec.sv
// seg_hex_dec: combinational nibble to active-low segment code.
module seg_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [7:0] o_seg
);

  // Table lookup through the shared decode function.
  always_comb o_seg = hex2seg(i_nib);

endmodule

// File: rtl/seg_hex_disp.sv
// seg_hex_disp: multiplexed common-anode hex display driver with per-slot
// dead-time and frame-boundary value loading (no tearing).
// Optional feature: define SEG_LZ_SUPPRESS_EN for leading-zero suppression.
module seg_hex_disp
  import seg_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int DIGITS   = 4,
  parameter int DEAD_CYC = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  seg_hex_disp_if.slave bus
);

  localparam int SCAN_DIV = CLK_FREQ / (SCAN_HZ * DIGITS);
  localparam int CNT_W    = $clog2(SCAN_DIV);
  localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (!((SCAN_DIV > DEAD_CYC) && (SCAN_DIV >= 2))) begin : g_bad_cfg
    $error("seg_hex_disp: SCAN_DIV must exceed DEAD_CYC and be at least 2");
  end

  logic [CNT_W-1:0]    r_div_cnt;
  logic [IDX_W-1:0]    r_dig_idx;
  logic [4*DIGITS-1:0] r_shadow;
  logic [4*DIGITS-1:0] r_frame;
  logic [7:0]          r_seg;
  logic [DIGITS-1:0]   r_sel;

  logic                w_wrap;
  logic                w_last_dig;
  logic                w_dead;
  logic [3:0]          w_nib;
  logic [7:0]          w_dec_seg;
  logic [DIGITS-1:0]   w_sel_lit;
  logic                w_lz;

  // Slot/frame position decode from the current state.
  always_comb begin
    w_wrap     = (r_div_cnt == CNT_W'(SCAN_DIV - 1));
    w_last_dig = (r_dig_idx == IDX_W'(DIGITS - 1));
    w_dead     = (r_div_cnt < CNT_W'(DEAD_CYC));
    w_sel_lit  = ~(DIGITS'(1) << r_dig_idx);
  end

  // Free-running slot divider and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_dig_idx <= '0;
    end else if (w_wrap) begin
      r_div_cnt <= '0;
      r_dig_idx <= w_last_dig ? '0 : r_dig_idx + 1'b1;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Strobe capture into shadow; shadow moves to frame only at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_frame  <= '0;
    end else begin
      if (bus.din_vld) r_shadow <= bus.din;
      if (w_wrap && w_last_dig) r_frame <= r_shadow;
    end
  end

  // Select the frame nibble for the digit being scanned.
  always_comb begin
    w_nib = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_dig_idx == IDX_W'(i)) w_nib = r_frame[4*i +: 4];
    end
  end

  seg_hex_dec u_dec (
    .i_nib (w_nib),
    .o_seg (w_dec_seg)
  );

`ifdef SEG_LZ_SUPPRESS_EN
  logic w_zero_run;

  // Blank digit i>0 when it and every more significant nibble are zero.
  always_comb begin
    w_zero_run = 1'b1;
    w_lz       = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run && (r_frame[4*i +: 4] == 4'h0);
      if (r_dig_idx == IDX_W'(i)) w_lz = w_zero_run;
    end
  end
`else
  // All digits always decode.
  always_comb w_lz = 1'b0;
`endif

  // Registered outputs: dark during blank or dead-time, else one digit lit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_OFF;
      r_sel <= '1;
    end else if (bus.blank || w_dead) begin
      r_seg <= SEG_OFF;
      r_sel <= '1;
    end else begin
      r_seg <= w_lz ? SEG_OFF : w_dec_seg;
      r_sel <= w_sel_lit;
    end
  end

  assign bus.seg = r_seg;
  assign bus.sel = r_sel;

endmodule

// File: tb/tb_seg_hex_disp.sv
// tb_seg_hex_disp: directed bench for seg_hex_disp with SCAN_DIV=20, 80-cycle frames.
// e counts rising edges since the last reset release; the output seen just
// after edge e reflects the scan position (e-1).
module tb_seg_hex_disp;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   e;

  logic [7:0] seg_tbl [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  seg_hex_disp_if #(.DIGITS(4)) bus ();

  seg_hex_disp #(
    .CLK_FREQ (80000),
    .SCAN_HZ  (1000),
    .DIGITS   (4),
    .DEAD_CYC (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  // Advance one edge and check both outputs for a frame showing val.
  task automatic step(input string tag, input logic [15:0] val);
    logic       bl;
    int         pos;
    int         d;
    logic [7:0] exp_seg;
    logic [3:0] exp_sel;
    logic [15:0] upper;
    bl = bus.blank;
    @(posedge clk);
    #1;
    e++;
    pos = (e - 1) % 20;
    d   = ((e - 1) / 20) % 4;
    exp_seg = 8'hFF;
    exp_sel = 4'hF;
    if (!bl && pos >= 2) begin
      exp_sel[d] = 1'b0;
      upper      = val >> (4 * d);
      exp_seg    = seg_tbl[upper[3:0]];
`ifdef SEG_LZ_SUPPRESS_EN
      if (d > 0 && upper == 16'h0) exp_seg = 8'hFF;
`endif
    end
    chk({tag, "_seg"}, {24'h0, bus.seg}, {24'h0, exp_seg});
    chk({tag, "_sel"}, {28'h0, bus.sel}, {28'h0, exp_sel});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    e = 0;
    rst_n = 1'b0;
    bus.din = 16'h0;
    bus.din_vld = 1'b0;
    bus.blank = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", {24'h0, bus.seg}, 32'hFF);
    chk("rst_sel", {28'h0, bus.sel}, 32'hF);
    rst_n = 1'b1;
    e = 0;
    chk("c0_seg", {24'h0, bus.seg}, 32'hFF);
    chk("c0_sel", {28'h0, bus.sel}, 32'hF);

    // Frame 0: reset value zero.
    repeat (80) step("f0", 16'h0000);

    // Frame 1: strobe 12AF mid-frame, display must still show the old value.
    repeat (80) begin
      step("f1", 16'h0000);
      if (e == 100) begin
        bus.din = 16'h12AF;
        bus.din_vld = 1'b1;
      end else begin
        bus.din_vld = 1'b0;
      end
    end

    // Frame 2: 12AF. Frame 3: back-to-back strobes, last wins next frame.
    repeat (80) step("f2", 16'h12AF);
    repeat (80) begin
      step("f3", 16'h12AF);
      if (e == 270) begin
        bus.din = 16'h1111;
        bus.din_vld = 1'b1;
      end else if (e == 271) begin
        bus.din = 16'h2222;
        bus.din_vld = 1'b1;
      end else begin
        bus.din_vld = 1'b0;
      end
    end

    // Frame 4: 2222, blank for 30 edges across a slot boundary; strobe on
    // the frame-boundary edge must wait an extra frame.
    repeat (80) begin
      step("f4", 16'h2222);
      if (e == 335) bus.blank = 1'b1;
      if (e == 365) bus.blank = 1'b0;
      if (e == 399) begin
        bus.din = 16'h0050;
        bus.din_vld = 1'b1;
      end else begin
        bus.din_vld = 1'b0;
      end
    end
    repeat (80) step("f5", 16'h2222);
    repeat (80) step("f6", 16'h0050);

    // Reset while digit 2 is lit.
    repeat (51) step("f7", 16'h0050);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_seg", {24'h0, bus.seg}, 32'hFF);
    chk("arst_sel", {28'h0, bus.sel}, 32'hF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    e = 0;
    chk("rel_seg", {24'h0, bus.seg}, 32'hFF);
    chk("rel_sel", {28'h0, bus.sel}, 32'hF);
    repeat (80) step("post_rst", 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_hex_disp.md
# seg_hex_disp

Multiplexed seven-segment driver that shows a packed hexadecimal value on `DIGITS` common-anode digits. It is the output-side counterpart of the push-button front end: the key counter is written in with a strobe, and this block scans the value onto the board's display. The scan is free-running, with a per-digit dead-time to suppress ghosting. The displayed value changes only at frame boundaries, so the display never tears.

## Interface
- `CLK_FREQ`, 50_000_000: `clk` frequency in Hz.
- `SCAN_HZ`, 1000: full-frame refresh rate in Hz.
- `DIGITS`, 4: number of digits (1..8).
- `DEAD_CYC`, 16: blanked `clk` cycles at the start of each digit slot.
- Derived constant `SCAN_DIV` = `CLK_FREQ/(SCAN_HZ*DIGITS)`.
  - Elaboration error unless `SCAN_DIV > DEAD_CYC` and `SCAN_DIV >= 2`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `din` in 4*DIGITS: value to display; nibble i goes to digit i, digit 0 is rightmost.
- `din_vld` in 1: one-cycle strobe that captures `din`.
- `blank` in 1: level; forces the display dark.
- `seg` out 8: active-low segment outputs, registered.
  - `seg[0..6]` = a..g.
  - `seg[7]` = dp, held at 1.
- `sel` out DIGITS: active-low digit enables, registered, at most one bit low.

## Operation
- Reset values:
  - `seg` = 8'hFF.
  - `sel` = all ones.
  - `div_cnt` = 0, `dig_idx` = 0.
  - `shadow` = 0, `frame` = 0.
- Capture: if `din_vld`=1, `shadow` <= `din` on that edge. Back-to-back strobes are allowed; the last one wins.
- Divider: `div_cnt` counts 0..SCAN_DIV-1, then wraps to 0.
- Digit advance: on the wrap, `dig_idx` advances and wraps from DIGITS-1 to 0.
- Frame load: on the same edge that `dig_idx` wraps DIGITS-1 -> 0, `frame` <= `shadow`.
  - A `din_vld` on that edge writes `shadow` but is not seen by `frame` until the next frame boundary.
- Output register, updated every edge from the current state:
  - `blank`=1 or `div_cnt` < DEAD_CYC: `seg`=8'hFF, `sel`=all ones.
  - Otherwise: `sel` bit `dig_idx` = 0, other bits 1; `seg` = decode(`frame` nibble `dig_idx`).
- Decode (seg[7:0] active-low):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8.
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- `blank` does not stop the divider, indices or capture; releasing it resumes mid-slot with no phase change.
- Reset asserted mid-scan forces the reset values immediately (asynchronous). The scan restarts at digit 0, slot start, dead-time first.

## Timing
- Outputs lag the state by 1 cycle (single register stage).
- Slot length is SCAN_DIV cycles: DEAD_CYC cycles dark, then SCAN_DIV-DEAD_CYC cycles lit.
- Frame length is DIGITS*SCAN_DIV cycles.
- Strobe to display:
  - Worst case: DIGITS*SCAN_DIV + DEAD_CYC + 1 cycles.
  - Best case: a strobe on the last cycle of a frame appears in digit 0 after DEAD_CYC+2 cycles.
- `blank` takes effect on the outputs 1 cycle after it is sampled.

## Configuration
- Macro `SEG_LZ_SUPPRESS_EN` enables leading-zero suppression.
- Defined:
  - Digit i>0 shows `seg`=8'hFF, with `sel` still driven, when nibbles i..DIGITS-1 of `frame` are all zero.
  - Digit 0 always shows.
  - Example: 16'h0050 shows as "  50".
- Undefined: all digits always decode, so 16'h0050 shows as "0050".

## Structure
- Package `seg_pkg` holds:
  - The 16-entry active-low decode constant and function `hex2seg(logic [3:0]) -> logic [7:0]`.
  - `SEG_OFF` = 8'hFF.
- One sub-module `seg_hex_dec` (combinational nibble -> seg using `hex2seg`) is natural; instantiate it once on the muxed nibble.
- Top holds the divider, index, `shadow`/`frame` registers, suppression logic and output register.

## Test plan
Bench parameters: CLK_FREQ=80000, SCAN_HZ=1000, DIGITS=4, DEAD_CYC=2, so SCAN_DIV=20 and a frame is 80 cycles.
- Reset release, no strobe -> all outputs dark for cycles 0..2. Then `sel`=4'b1110 and `seg`=C0 for cycles 3..20, then `sel`=4'b1101.
- `din`=16'h12AF with `din_vld` one cycle -> over the next full frame, digits 0..3 show 8E, 88, A4, F9 in order. No digit ever shows a mixed old/new value.
- Strobe 16'h1111 then 16'h2222 on consecutive cycles mid-frame -> the next frame shows A4 on all digits; F9 never appears.
- `blank`=1 for 30 cycles spanning a slot boundary -> `seg`=FF and `sel`=4'b1111 throughout. After release, the slot phase matches the unblanked reference count.
- `rst_n` pulsed low while digit 2 is lit -> outputs go dark with no clock edge. After release, digit 0 is lit 3 cycles later and `frame`=0.
- With `SEG_LZ_SUPPRESS_EN`, `din`=16'h0050 -> digits 3 and 2 show FF, digit 1 shows 92, digit 0 shows C0. With `din`=0, only digit 0 shows C0.
